// File: rtl/seq_stage_ctrl_if.sv
// Stage-facing bundle of the SEQ sequencer: fault flags and next PC in,
// current PC and one-hot stage enables out.
interface seq_stage_ctrl_if;
  logic        bad_mem;
  logic        in_error;
  logic        flag_halt;
  logic        bad_mem2;
  logic [63:0] p_ctr_final;
  logic [63:0] p_ctr;
  logic        fetch_en;
  logic        decode_en;
  logic        exe_en;
  logic        mem_en;
  logic        wb_en;
  logic        pc_en;

  modport master (
    input  bad_mem, in_error, flag_halt, bad_mem2, p_ctr_final,
    output p_ctr, fetch_en, decode_en, exe_en, mem_en, wb_en, pc_en
  );

  modport slave (
    output bad_mem, in_error, flag_halt, bad_mem2, p_ctr_final,
    input  p_ctr, fetch_en, decode_en, exe_en, mem_en, wb_en, pc_en
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: owns the PC, walks the
// six stage enables, folds stage faults into the status code and parks on halt/fault.
module seq_stage_ctrl #(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  seq_stage_ctrl_if.master stage,
  output logic [3:0]       en_coder,
  output logic             halted,
  output logic             busy,
  output logic [31:0]      insn_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_STOP      = 3'd7
  } state_t;

  localparam logic [3:0] CODE_AOK = 4'b1000;
  localparam logic [3:0] CODE_HLT = 4'b0010;
  localparam logic [3:0] CODE_ADR = 4'b0001;
  localparam logic [3:0] CODE_INS = 4'b0100;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  code_next_s;
  logic        step_mode_r;
  logic        step_mode_next_s;
  logic [5:0]  en_r;
  logic [63:0] p_ctr_r;
  logic        in_stage_s;

  // Enable order, MSB first: fetch, decode, execute, memory, writeback, pc update.
  function automatic logic [5:0] stage_onehot(input state_t s);
    logic [5:0] v;
    case (s)
      ST_FETCH:     v = 6'b100000;
      ST_DECODE:    v = 6'b010000;
      ST_EXECUTE:   v = 6'b001000;
      ST_MEMORY:    v = 6'b000100;
      ST_WRITEBACK: v = 6'b000010;
      ST_PCUPD:     v = 6'b000001;
      default:      v = 6'b000000;
    endcase
    return v;
  endfunction

  assign in_stage_s = (state_r != ST_IDLE) && (state_r != ST_STOP);

  // Next-state, next status code and step-mode flag.
  always_comb begin
    state_next_s     = state_r;
    code_next_s      = en_coder;
    step_mode_next_s = step_mode_r;
    case (state_r)
      ST_IDLE: begin
        if (run || step) begin
          state_next_s     = ST_FETCH;
          step_mode_next_s = step & ~run;
        end else begin
          state_next_s     = ST_IDLE;
          step_mode_next_s = 1'b0;
        end
      end
      ST_FETCH: begin
        if (stage.bad_mem) begin
          state_next_s = ST_STOP;
          code_next_s  = CODE_ADR;
        end else if (stage.in_error) begin
          state_next_s = ST_STOP;
          code_next_s  = CODE_INS;
        end else if (stage.flag_halt) begin
          state_next_s = ST_STOP;
          code_next_s  = CODE_HLT;
        end else begin
          state_next_s = ST_DECODE;
        end
      end
      ST_DECODE:  state_next_s = ST_EXECUTE;
      ST_EXECUTE: state_next_s = ST_MEMORY;
      ST_MEMORY: begin
        if (stage.bad_mem2) begin
          state_next_s = ST_STOP;
          code_next_s  = CODE_ADR;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: state_next_s = ST_PCUPD;
      ST_PCUPD: begin
        if (run && !step_mode_r) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s     = ST_IDLE;
          step_mode_next_s = 1'b0;
        end
      end
      ST_STOP: state_next_s = ST_STOP;
      default: state_next_s = ST_STOP;
    endcase
  end

  // State, status, enables, PC and counters; enables/busy/halted are registered
  // from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      step_mode_r <= 1'b0;
      en_coder    <= CODE_AOK;
      halted      <= 1'b0;
      busy        <= 1'b0;
      en_r        <= 6'b000000;
      p_ctr_r     <= PC_RESET;
      insn_count  <= 32'd0;
      cycle_count <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      step_mode_r <= step_mode_next_s;
      en_coder    <= code_next_s;
      halted      <= (state_next_s == ST_STOP);
      busy        <= (state_next_s != ST_IDLE) && (state_next_s != ST_STOP);
      en_r        <= stage_onehot(state_next_s);
      if (state_r == ST_PCUPD) begin
        p_ctr_r    <= stage.p_ctr_final;
        insn_count <= insn_count + 32'd1;
      end
      if (in_stage_s && (cycle_count != 32'hFFFF_FFFF)) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  assign stage.p_ctr     = p_ctr_r;
  assign stage.fetch_en  = en_r[5];
  assign stage.decode_en = en_r[4];
  assign stage.exe_en    = en_r[3];
  assign stage.mem_en    = en_r[2];
  assign stage.wb_en     = en_r[1];
  assign stage.pc_en     = en_r[0];

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: a vector table for run/halt/reset plus
// hand-written step, run-drop, fault-priority and mid-instruction reset sequences.
module tb_seq_stage_ctrl;

  localparam logic [63:0] PCR = 64'h0000_0000_0000_1000;
  localparam logic [5:0] E_0 = 6'b000000;
  localparam logic [5:0] E_F = 6'b100000;
  localparam logic [5:0] E_D = 6'b010000;
  localparam logic [5:0] E_X = 6'b001000;
  localparam logic [5:0] E_M = 6'b000100;
  localparam logic [5:0] E_W = 6'b000010;
  localparam logic [5:0] E_P = 6'b000001;
  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0010;
  localparam logic [3:0] ADR = 4'b0001;
  localparam logic [3:0] INS = 4'b0100;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clock;
  logic        reset;
  logic        run;
  logic        step;
  logic [3:0]  en_coder;
  logic        halted;
  logic        busy;
  logic [31:0] insn_count;
  logic [31:0] cycle_count;

  int total;
  int bad;

  seq_stage_ctrl_if ifc ();

  seq_stage_ctrl #(.PC_RESET(PCR)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .stage       (ifc.master),
    .en_coder    (en_coder),
    .halted      (halted),
    .busy        (busy),
    .insn_count  (insn_count),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, run_i, step_i, bm, ie, fh, bm2;
    logic [63:0] pcf;
    logic [5:0]  en;
    logic [3:0]  code;
    logic        hlt, bsy;
    logic [63:0] pc;
    logic [31:0] ic, cc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, run_i, step_i, bm, ie, fh, bm2,
                              input logic [63:0] pcf, input logic [5:0] en,
                              input logic [3:0] code, input logic hlt, bsy,
                              input logic [63:0] pc, input logic [31:0] ic, cc);
    vec_t v;
    v.rst = rst; v.run_i = run_i; v.step_i = step_i;
    v.bm = bm; v.ie = ie; v.fh = fh; v.bm2 = bm2; v.pcf = pcf;
    v.en = en; v.code = code; v.hlt = hlt; v.bsy = bsy;
    v.pc = pc; v.ic = ic; v.cc = cc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_flags();
    ifc.bad_mem = 1'b0; ifc.in_error = 1'b0; ifc.flag_halt = 1'b0; ifc.bad_mem2 = 1'b0;
  endtask

  task automatic check(input string tag, input logic [5:0] en_e, input logic [3:0] code_e,
                       input logic hlt_e, bsy_e, input logic [63:0] pc_e,
                       input logic [31:0] ic_e, cc_e);
    logic [5:0] en_a;
    en_a = {ifc.fetch_en, ifc.decode_en, ifc.exe_en, ifc.mem_en, ifc.wb_en, ifc.pc_en};
    total++;
    if ({en_a, en_coder, halted, busy, ifc.p_ctr, insn_count, cycle_count} !==
        {en_e, code_e, hlt_e, bsy_e, pc_e, ic_e, cc_e}) begin
      bad++;
      $display("FAIL %s: got en=%b code=%b halted=%b busy=%b pc=%h ic=%0d cc=%0d; want en=%b code=%b halted=%b busy=%b pc=%h ic=%0d cc=%0d",
               tag, en_a, en_coder, halted, busy, ifc.p_ctr, insn_count, cycle_count,
               en_e, code_e, hlt_e, bsy_e, pc_e, ic_e, cc_e);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; run = 1'b0; step = 1'b0; clear_flags();
    tick();
    check(tag, E_0, AOK, O, O, PCR, 32'd0, 32'd0);
    reset = 1'b0;
  endtask

  // Drives one instruction's six stage cycles; pcf_prev feeds the edge entering FETCH.
  task automatic run_insn(input string tag, input logic start_run, start_step, hold_run,
                          input logic [63:0] pcf_prev, pc0, input logic [31:0] ic0, cc0);
    logic [5:0] en_e;
    run = start_run; step = start_step; ifc.p_ctr_final = pcf_prev;
    en_e = E_F;
    for (int k = 0; k < 6; k++) begin
      tick();
      check(tag, en_e, AOK, O, I, pc0, ic0, cc0 + 32'(k));
      en_e = en_e >> 1;
      step = 1'b0; run = hold_run; ifc.p_ctr_final = JUNK;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; run = 1'b0; step = 1'b0; clear_flags(); ifc.p_ctr_final = JUNK;

    // rst run step bm ie fh bm2 pcf | en code hlt bsy pc ic cc
    tbl.push_back(mk(I,O,O,O,O,O,O,JUNK,     E_0,AOK,O,O,PCR,       32'd0,32'd0));
    tbl.push_back(mk(O,O,O,O,O,O,O,JUNK,     E_0,AOK,O,O,PCR,       32'd0,32'd0));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_F,AOK,O,I,PCR,       32'd0,32'd0));
    tbl.push_back(mk(O,I,O,O,O,O,I,JUNK,     E_D,AOK,O,I,PCR,       32'd0,32'd1));
    tbl.push_back(mk(O,I,O,I,I,O,O,JUNK,     E_X,AOK,O,I,PCR,       32'd0,32'd2));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_M,AOK,O,I,PCR,       32'd0,32'd3));
    tbl.push_back(mk(O,I,O,I,O,O,O,JUNK,     E_W,AOK,O,I,PCR,       32'd0,32'd4));
    tbl.push_back(mk(O,I,O,O,O,O,I,JUNK,     E_P,AOK,O,I,PCR,       32'd0,32'd5));
    tbl.push_back(mk(O,I,O,O,O,O,O,PCR+64'd10,E_F,AOK,O,I,PCR+64'd10,32'd1,32'd6));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_D,AOK,O,I,PCR+64'd10,32'd1,32'd7));
    tbl.push_back(mk(O,I,O,O,O,I,O,JUNK,     E_X,AOK,O,I,PCR+64'd10,32'd1,32'd8));
    tbl.push_back(mk(O,I,I,O,O,O,O,JUNK,     E_M,AOK,O,I,PCR+64'd10,32'd1,32'd9));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_W,AOK,O,I,PCR+64'd10,32'd1,32'd10));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_P,AOK,O,I,PCR+64'd10,32'd1,32'd11));
    tbl.push_back(mk(O,I,O,O,O,O,O,PCR+64'd20,E_F,AOK,O,I,PCR+64'd20,32'd2,32'd12));
    tbl.push_back(mk(O,I,O,O,O,I,O,JUNK,     E_0,HLT,I,O,PCR+64'd20,32'd2,32'd13));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_0,HLT,I,O,PCR+64'd20,32'd2,32'd13));
    tbl.push_back(mk(O,I,I,O,O,O,I,PCR+64'd99,E_0,HLT,I,O,PCR+64'd20,32'd2,32'd13));
    tbl.push_back(mk(I,I,O,O,O,O,O,JUNK,     E_0,AOK,O,O,PCR,       32'd0,32'd0));
    tbl.push_back(mk(O,I,O,O,O,O,O,JUNK,     E_F,AOK,O,I,PCR,       32'd0,32'd0));
    tbl.push_back(mk(I,O,O,O,O,O,O,JUNK,     E_0,AOK,O,O,PCR,       32'd0,32'd0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; run = tbl[i].run_i; step = tbl[i].step_i;
      ifc.bad_mem = tbl[i].bm; ifc.in_error = tbl[i].ie;
      ifc.flag_halt = tbl[i].fh; ifc.bad_mem2 = tbl[i].bm2;
      ifc.p_ctr_final = tbl[i].pcf;
      tick();
      check($sformatf("vec%0d", i), tbl[i].en, tbl[i].code, tbl[i].hlt, tbl[i].bsy,
            tbl[i].pc, tbl[i].ic, tbl[i].cc);
    end

    // Three back-to-back instructions, then run drops and the FSM parks.
    do_reset("run3_rst");
    run_insn("run3_i0", I, O, I, JUNK, PCR, 32'd0, 32'd0);
    run_insn("run3_i1", I, O, I, PCR + 64'd10, PCR + 64'd10, 32'd1, 32'd6);
    run_insn("run3_i2", I, O, O, PCR + 64'd20, PCR + 64'd20, 32'd2, 32'd12);
    ifc.p_ctr_final = PCR + 64'd30;
    tick();
    check("run3_idle", E_0, AOK, O, O, PCR + 64'd30, 32'd3, 32'd18);

    // Single step twice; cycle_count frozen while idle.
    do_reset("step_rst");
    run_insn("step1", O, I, O, JUNK, PCR, 32'd0, 32'd0);
    ifc.p_ctr_final = 64'h40;
    tick();
    check("step1_idle", E_0, AOK, O, O, 64'h40, 32'd1, 32'd6);
    ifc.p_ctr_final = JUNK;
    tick();
    check("step1_park", E_0, AOK, O, O, 64'h40, 32'd1, 32'd6);
    run_insn("step2", O, I, O, JUNK, 64'h40, 32'd1, 32'd6);
    ifc.p_ctr_final = 64'h80;
    tick();
    check("step2_idle", E_0, AOK, O, O, 64'h80, 32'd2, 32'd12);

    // run held for one cycle only: the instruction still completes.
    do_reset("drop_rst");
    run_insn("drop", I, O, O, JUNK, PCR, 32'd0, 32'd0);
    ifc.p_ctr_final = 64'h18;
    tick();
    check("drop_idle", E_0, AOK, O, O, 64'h18, 32'd1, 32'd6);

    // Data fault in MEMORY: no writeback, no PC update.
    do_reset("bm2_rst");
    run = 1'b1;
    tick(); tick(); tick(); tick();
    check("bm2_mem", E_M, AOK, O, I, PCR, 32'd0, 32'd3);
    ifc.bad_mem2 = 1'b1; ifc.p_ctr_final = 64'h77;
    tick();
    check("bm2_stop", E_0, ADR, I, O, PCR, 32'd0, 32'd4);
    ifc.bad_mem2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bm2_hold%0d", k), E_0, ADR, I, O, PCR, 32'd0, 32'd4);
    end

    // Fetch flag priority.
    do_reset("pri_rst0");
    run = 1'b1;
    tick();
    ifc.bad_mem = 1'b1; ifc.in_error = 1'b1;
    tick();
    check("pri_adr_ins", E_0, ADR, I, O, PCR, 32'd0, 32'd1);
    do_reset("pri_rst1");
    run = 1'b1;
    tick();
    ifc.in_error = 1'b1;
    tick();
    check("pri_ins", E_0, INS, I, O, PCR, 32'd0, 32'd1);
    do_reset("pri_rst2");
    run = 1'b1;
    tick();
    ifc.bad_mem = 1'b1; ifc.flag_halt = 1'b1;
    tick();
    check("pri_adr_hlt", E_0, ADR, I, O, PCR, 32'd0, 32'd1);

    // Reset while in EXECUTE of the second instruction.
    do_reset("mid_rst0");
    run_insn("mid_i0", I, O, I, JUNK, PCR, 32'd0, 32'd0);
    ifc.p_ctr_final = PCR + 64'd30;
    tick();
    check("mid_fetch", E_F, AOK, O, I, PCR + 64'd30, 32'd1, 32'd6);
    ifc.p_ctr_final = JUNK;
    tick(); tick();
    check("mid_exe", E_X, AOK, O, I, PCR + 64'd30, 32'd1, 32'd8);
    reset = 1'b1;
    tick();
    check("mid_reset", E_0, AOK, O, O, PCR, 32'd0, 32'd0);
    reset = 1'b0; run = 1'b0;
    tick();
    check("mid_idle", E_0, AOK, O, O, PCR, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
